ts_os_receiver: RTL and testbench

TS_OS_RECEIVER -- requirements
Module: ts_os_receiver

---
 rtl/ltssm_pkg.sv | 27 ++
 rtl/ts_consec_counter.sv | 39 +++
 rtl/ts_os_receiver.sv | 156 +++++++++++++++
 tb/tb_ts_os_receiver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: ordered-set symbol codes, TS identifiers and
// the training-set receiver state/field types.
package ltssm_pkg;

    localparam logic [7:0] COM_CODE = 8'hBC;
    localparam logic [7:0] PAD_CODE = 8'hF7;
    localparam logic [7:0] TS1_ID   = 8'h4A;
    localparam logic [7:0] TS2_ID   = 8'h45;

    localparam logic [3:0] TS_LAST_IDX = 4'd15;

    typedef enum logic {
        HUNT,
        COLLECT
    } ts_rx_st_e;

    // Fields that must repeat for two training sets to count as consecutive
    typedef struct packed {
        logic       ts2;
        logic [7:0] link;
        logic [7:0] lane;
        logic       link_pad;
        logic       lane_pad;
        logic [7:0] rate;
    } ts_key_t;

endpackage

// File: rtl/ts_consec_counter.sv
// Counts consecutive identical training sets, saturating at CONSEC_TARGET.
module ts_consec_counter
    import ltssm_pkg::*;
#(
    parameter int CONSEC_TARGET = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       update_i,
    input  logic       error_i,
    input  logic       clear_i,
    input  ts_key_t    new_key_i,
    input  ts_key_t    base_key_i,
    output logic [3:0] cnt_o,
    output logic       met_o
);

    localparam logic [3:0] TARGET = 4'(CONSEC_TARGET);

    // A zero count means there is no valid baseline, so the next TS loads 1
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= 4'd0;
        end else if (clear_i || error_i) begin
            cnt_o <= 4'd0;
        end else if (update_i) begin
            if ((new_key_i == base_key_i) && (cnt_o != 4'd0)) begin
                if (cnt_o < TARGET) begin
                    cnt_o <= cnt_o + 4'd1;
                end
            end else begin
                cnt_o <= 4'd1;
            end
        end
    end

    assign met_o = (cnt_o == TARGET);

endmodule

// File: rtl/ts_os_receiver.sv
// TS1/TS2 ordered-set receiver: hunts for COM, validates 16 symbols and
// publishes the captured fields with a consecutive-match count.
module ts_os_receiver
    import ltssm_pkg::*;
#(
    parameter int CONSEC_TARGET = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sym_valid_i,
    input  logic [7:0] sym_data_i,
    input  logic       sym_is_k_i,
    input  logic       clear_count_i,
    output logic       ts_valid_o,
    output logic       ts_is_ts2_o,
    output logic [7:0] link_num_o,
    output logic [7:0] lane_num_o,
    output logic       link_pad_o,
    output logic       lane_pad_o,
    output logic [7:0] n_fts_o,
    output logic [7:0] rate_id_o,
    output logic [7:0] train_ctl_o,
    output logic [3:0] consec_cnt_o,
    output logic       consec_met_o,
    output logic       os_err_o
);

    ts_rx_st_e  st, st_n;
    logic [3:0] idx, idx_n;
    logic       sym_ok, sym_err, ts_done, is_com, is_pad;

    logic [7:0] p_link, p_lane, p_nfts, p_rate, p_ctl, p_id;
    logic       p_link_pad, p_lane_pad;
    ts_key_t    new_key, base_key;

    assign is_com = sym_is_k_i && (sym_data_i == COM_CODE);
    assign is_pad = sym_is_k_i && (sym_data_i == PAD_CODE);

    always_comb begin
        sym_ok = 1'b0;
        case (idx)
            4'd1, 4'd2:       sym_ok = !sym_is_k_i || is_pad;
            4'd3, 4'd4, 4'd5: sym_ok = !sym_is_k_i;
            4'd6:             sym_ok = !sym_is_k_i &&
                                       ((sym_data_i == TS1_ID) || (sym_data_i == TS2_ID));
            default:          sym_ok = !sym_is_k_i && (sym_data_i == p_id);
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st  <= HUNT;
            idx <= 4'd0;
        end else begin
            st  <= st_n;
            idx <= idx_n;
        end
    end

    // A COM that breaks a set is itself the start of the next one
    always_comb begin
        st_n    = st;
        idx_n   = idx;
        sym_err = 1'b0;
        ts_done = 1'b0;
        if (sym_valid_i) begin
            if (st == HUNT) begin
                if (is_com) begin
                    st_n  = COLLECT;
                    idx_n = 4'd1;
                end
            end else if (!sym_ok) begin
                sym_err = 1'b1;
                st_n    = is_com ? COLLECT : HUNT;
                idx_n   = is_com ? 4'd1 : 4'd0;
            end else if (idx == TS_LAST_IDX) begin
                ts_done = 1'b1;
                st_n    = HUNT;
                idx_n   = 4'd0;
            end else begin
                idx_n = idx + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            p_link     <= 8'd0;
            p_lane     <= 8'd0;
            p_link_pad <= 1'b0;
            p_lane_pad <= 1'b0;
            p_nfts     <= 8'd0;
            p_rate     <= 8'd0;
            p_ctl      <= 8'd0;
            p_id       <= 8'd0;
        end else if (sym_valid_i && (st == COLLECT) && sym_ok) begin
            case (idx)
                4'd1: begin p_link <= sym_data_i; p_link_pad <= is_pad; end
                4'd2: begin p_lane <= sym_data_i; p_lane_pad <= is_pad; end
                4'd3: p_nfts <= sym_data_i;
                4'd4: p_rate <= sym_data_i;
                4'd5: p_ctl  <= sym_data_i;
                4'd6: p_id   <= sym_data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ts_valid_o  <= 1'b0;
            os_err_o    <= 1'b0;
            ts_is_ts2_o <= 1'b0;
            link_num_o  <= 8'd0;
            lane_num_o  <= 8'd0;
            link_pad_o  <= 1'b0;
            lane_pad_o  <= 1'b0;
            n_fts_o     <= 8'd0;
            rate_id_o   <= 8'd0;
            train_ctl_o <= 8'd0;
        end else begin
            ts_valid_o <= ts_done;
            os_err_o   <= sym_err;
            if (ts_done) begin
                ts_is_ts2_o <= new_key.ts2;
                link_num_o  <= p_link;
                lane_num_o  <= p_lane;
                link_pad_o  <= p_link_pad;
                lane_pad_o  <= p_lane_pad;
                n_fts_o     <= p_nfts;
                rate_id_o   <= p_rate;
                train_ctl_o <= p_ctl;
            end
        end
    end

    assign new_key  = '{ts2: (p_id == TS2_ID), link: p_link, lane: p_lane,
                        link_pad: p_link_pad, lane_pad: p_lane_pad, rate: p_rate};
    assign base_key = '{ts2: ts_is_ts2_o, link: link_num_o, lane: lane_num_o,
                        link_pad: link_pad_o, lane_pad: lane_pad_o, rate: rate_id_o};

    ts_consec_counter #(
        .CONSEC_TARGET(CONSEC_TARGET)
    ) u_consec (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .update_i  (ts_done),
        .error_i   (sym_err),
        .clear_i   (clear_count_i),
        .new_key_i (new_key),
        .base_key_i(base_key),
        .cnt_o     (consec_cnt_o),
        .met_o     (consec_met_o)
    );

endmodule

// File: tb/tb_ts_os_receiver.sv
// Self-checking bench for ts_os_receiver: table of training sets plus
// hand-built error, gap, clear and reset sequences against a pulse scoreboard.
module tb_ts_os_receiver;
    import ltssm_pkg::*;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       sym_valid_i = 1'b0;
    logic [7:0] sym_data_i = 8'd0;
    logic       sym_is_k_i = 1'b0;
    logic       clear_count_i = 1'b0;
    logic       ts_valid_o, ts_is_ts2_o, link_pad_o, lane_pad_o;
    logic       consec_met_o, os_err_o;
    logic [7:0] link_num_o, lane_num_o, n_fts_o, rate_id_o, train_ctl_o;
    logic [3:0] consec_cnt_o;

    ts_os_receiver #(.CONSEC_TARGET(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .sym_valid_i(sym_valid_i), .sym_data_i(sym_data_i), .sym_is_k_i(sym_is_k_i),
        .clear_count_i(clear_count_i),
        .ts_valid_o(ts_valid_o), .ts_is_ts2_o(ts_is_ts2_o),
        .link_num_o(link_num_o), .lane_num_o(lane_num_o),
        .link_pad_o(link_pad_o), .lane_pad_o(lane_pad_o),
        .n_fts_o(n_fts_o), .rate_id_o(rate_id_o), .train_ctl_o(train_ctl_o),
        .consec_cnt_o(consec_cnt_o), .consec_met_o(consec_met_o), .os_err_o(os_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       ts2;
        logic [7:0] link, lane;
        logic       lpad, npad;
        logic [7:0] nfts, rate, ctl;
        logic [3:0] cnt;
        logic       met;
    } vec_t;

    typedef struct {
        logic       err;
        logic       ts2;
        logic [7:0] link, lane;
        logic       lpad, npad;
        logic [7:0] nfts, rate, ctl;
        logic [3:0] cnt;
        logic       met;
    } exp_t;

    exp_t sb_q[$];
    exp_t pend;
    exp_t last;
    logic pend_valid = 1'b0;
    logic gap_en = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    vec_t vecs[16];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic compare_event(input exp_t e);
        check_output("ts_valid",  32'(ts_valid_o),   32'(!e.err));
        check_output("os_err",    32'(os_err_o),     32'(e.err));
        check_output("ts_is_ts2", 32'(ts_is_ts2_o),  32'(e.ts2));
        check_output("link_num",  32'(link_num_o),   32'(e.link));
        check_output("lane_num",  32'(lane_num_o),   32'(e.lane));
        check_output("link_pad",  32'(link_pad_o),   32'(e.lpad));
        check_output("lane_pad",  32'(lane_pad_o),   32'(e.npad));
        check_output("n_fts",     32'(n_fts_o),      32'(e.nfts));
        check_output("rate_id",   32'(rate_id_o),    32'(e.rate));
        check_output("train_ctl", 32'(train_ctl_o),  32'(e.ctl));
        check_output("consec_cnt",32'(consec_cnt_o), 32'(e.cnt));
        check_output("consec_met",32'(consec_met_o), 32'(e.met));
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic k, input logic clr);
        exp_t e;
        sym_valid_i   = v;
        sym_data_i    = d;
        sym_is_k_i    = k;
        clear_count_i = clr;
        @(posedge clk_i);
        #1;
        if (ts_valid_o || os_err_o) begin
            if (sb_q.size() == 0) begin
                check_output("unexpected_pulse", {30'd0, ts_valid_o, os_err_o}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                compare_event(e);
            end
        end else if (sb_q.size() != 0) begin
            check_output("missing_pulse", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
    endtask

    task automatic sym(input logic [7:0] d, input logic k, input logic clr = 1'b0);
        if (gap_en) begin
            for (int g = 0; g < 3 && $urandom_range(1, 0) == 1; g++)
                apply_stimulus(1'b0, 8'($urandom), 1'($urandom_range(1, 0)), 1'b0);
        end
        if (pend_valid) begin
            sb_q.push_back(pend);
            pend_valid = 1'b0;
        end
        apply_stimulus(1'b1, d, k, clr);
    endtask

    task automatic expect_err();
        pend       = last;
        pend.err   = 1'b1;
        pend.cnt   = 4'd0;
        pend.met   = 1'b0;
        pend_valid = 1'b1;
    endtask

    task automatic send_body(input vec_t v, input logic clr_last);
        logic [7:0] id;
        id = v.ts2 ? TS2_ID : TS1_ID;
        if (v.lpad) sym(PAD_CODE, 1'b1); else sym(v.link, 1'b0);
        if (v.npad) sym(PAD_CODE, 1'b1); else sym(v.lane, 1'b0);
        sym(v.nfts, 1'b0);
        sym(v.rate, 1'b0);
        sym(v.ctl, 1'b0);
        for (int i = 6; i < 15; i++) sym(id, 1'b0);
        pend = '{err: 1'b0, ts2: v.ts2,
                 link: v.lpad ? PAD_CODE : v.link, lane: v.npad ? PAD_CODE : v.lane,
                 lpad: v.lpad, npad: v.npad, nfts: v.nfts, rate: v.rate, ctl: v.ctl,
                 cnt: clr_last ? 4'd0 : v.cnt, met: clr_last ? 1'b0 : v.met};
        pend_valid = 1'b1;
        last = pend;
        sym(id, 1'b0, clr_last);
    endtask

    task automatic send_ts(input vec_t v, input logic clr_last = 1'b0);
        sym(COM_CODE, 1'b1);
        send_body(v, clr_last);
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_valid"}, 32'(ts_valid_o), 32'd0);
        check_output({tag, "_err"},   32'(os_err_o), 32'd0);
        check_output({tag, "_cnt"},   32'(consec_cnt_o), 32'd0);
        check_output({tag, "_met"},   32'(consec_met_o), 32'd0);
        check_output({tag, "_fields"},
                     {ts_is_ts2_o, link_pad_o, lane_pad_o, link_num_o, lane_num_o, n_fts_o},
                     32'd0);
        check_output({tag, "_rate_ctl"}, {16'd0, rate_id_o, train_ctl_o}, 32'd0);
    endtask

    initial begin
        #500us;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 8; i++)
            vecs[i] = '{ts2: 1'b0, link: 8'h00, lane: 8'h00, lpad: 1'b1, npad: 1'b1,
                        nfts: 8'h20, rate: 8'h02, ctl: 8'h00, cnt: 4'(i + 1), met: (i == 7)};
        for (int i = 8; i < 16; i++)
            vecs[i] = '{ts2: (i >= 12), link: 8'h05, lane: 8'h03, lpad: 1'b0, npad: 1'b0,
                        nfts: 8'h10, rate: 8'h02, ctl: 8'h01, cnt: 4'((i % 4) + 1), met: 1'b0};
        last = '{default: '0};

        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_i = 1'b0;
        apply_stimulus(1'b1, 8'h4A, 1'b0, 1'b0);
        apply_stimulus(1'b1, PAD_CODE, 1'b1, 1'b0);

        $display("[TB] eight back-to-back TS1 with PAD link/lane");
        for (int i = 0; i < 8; i++) send_ts(vecs[i]);

        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("clear_idle_cnt", 32'(consec_cnt_o), 32'd0);

        $display("[TB] four TS1 then four TS2 with identical fields");
        for (int i = 8; i < 16; i++) send_ts(vecs[i]);

        $display("[TB] TS1 with a TS2 identifier at index 9");
        v = '{ts2: 1'b0, link: 8'h07, lane: 8'h06, lpad: 1'b0, npad: 1'b0,
              nfts: 8'h33, rate: 8'h04, ctl: 8'h02, cnt: 4'd0, met: 1'b0};
        sym(COM_CODE, 1'b1);
        sym(v.link, 1'b0); sym(v.lane, 1'b0); sym(v.nfts, 1'b0);
        sym(v.rate, 1'b0); sym(v.ctl, 1'b0);
        for (int i = 6; i < 9; i++) sym(TS1_ID, 1'b0);
        expect_err();
        sym(TS2_ID, 1'b0);
        for (int i = 10; i < 16; i++) sym(TS1_ID, 1'b0);

        $display("[TB] COM injected at index 7");
        v = '{ts2: 1'b0, link: 8'h01, lane: 8'h02, lpad: 1'b0, npad: 1'b0,
              nfts: 8'h20, rate: 8'h02, ctl: 8'h00, cnt: 4'd1, met: 1'b0};
        sym(COM_CODE, 1'b1);
        sym(v.link, 1'b0); sym(v.lane, 1'b0); sym(v.nfts, 1'b0);
        sym(v.rate, 1'b0); sym(v.ctl, 1'b0); sym(TS1_ID, 1'b0);
        expect_err();
        sym(COM_CODE, 1'b1);
        send_body(v, 1'b0);

        $display("[TB] eight TS2 with random idle gaps, clear on the last");
        gap_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v = '{ts2: 1'b1, link: 8'h0A, lane: 8'h01, lpad: 1'b0, npad: 1'b0,
                  nfts: 8'h40, rate: 8'h04, ctl: 8'h08, cnt: 4'(i + 1), met: (i == 7)};
            send_ts(v, i == 7);
        end
        gap_en = 1'b0;

        $display("[TB] reset in the middle of an ordered set");
        v = '{ts2: 1'b0, link: 8'h11, lane: 8'h22, lpad: 1'b0, npad: 1'b0,
              nfts: 8'h08, rate: 8'h02, ctl: 8'h00, cnt: 4'd1, met: 1'b0};
        sym(COM_CODE, 1'b1);
        sym(v.link, 1'b0); sym(v.lane, 1'b0); sym(v.nfts, 1'b0);
        sym(v.rate, 1'b0); sym(v.ctl, 1'b0);
        for (int i = 6; i < 10; i++) sym(TS1_ID, 1'b0);
        rst_i = 1'b1;
        #1;
        check_all_zero("midreset");
        last = '{default: '0};
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 10; i < 16; i++) sym(TS1_ID, 1'b0);
        send_ts(v);

        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0);
        check_output("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
